// File: rtl/state_slice_sequencer_pkg.sv
// Shared types and constants for the state slice sequencer: FSM states,
// traversal order encodings and default grid geometry.
package state_slice_sequencer_pkg;

  localparam int SBOX_H = 4;
  localparam int SBOX_W = 4;

  typedef enum logic {
    ORDER_ROW = 1'b0,
    ORDER_COL = 1'b1
  } order_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Index width that stays at least one bit wide for degenerate grids.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/state_slice_sequencer_counter.sv
// Row/column position counter for the slice walk: steps by LANES in the
// selected order, wraps at the grid edge and flags the final beat.
module slice_index_counter
  import state_slice_sequencer_pkg::*;
#(
  parameter int ROWS  = SBOX_H,
  parameter int COLS  = SBOX_W,
  parameter int LANES = 1,
  parameter int RW    = idx_w(ROWS),
  parameter int CW    = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  order_t        mode,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_WRAP = RW'(ROWS - LANES);
  localparam logic [RW-1:0] ROW_STEP = RW'(LANES);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_WRAP = CW'(COLS - LANES);
  localparam logic [CW-1:0] COL_STEP = CW'(LANES);

  // The final beat is the last lane group of the last row (row-major)
  // or of the last column (column-major).
  always_comb begin
    last = 1'b0;
    if (mode == ORDER_COL) last = (col == COL_MAX) && (row == ROW_WRAP);
    else                   last = (row == ROW_MAX) && (col == COL_WRAP);
  end

  // clear beats step so a load coinciding with the final consume restarts at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (mode == ORDER_COL) begin
        if (row == ROW_WRAP) begin
          row <= '0;
          col <= (col == COL_MAX) ? '0 : col + CW'(1);
        end else begin
          row <= row + ROW_STEP;
        end
      end else begin
        if (col == COL_WRAP) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + RW'(1);
        end else begin
          col <= col + COL_STEP;
        end
      end
    end
  end

endmodule

// File: rtl/state_slice_sequencer.sv
// Serialises a ROWS x COLS block of BYTE_W-bit slices into handshaked beats
// of LANES slices, walking the grid in row- or column-major order.
module state_slice_sequencer
  import state_slice_sequencer_pkg::*;
#(
  parameter int ROWS   = SBOX_H,
  parameter int COLS   = SBOX_W,
  parameter int BYTE_W = 8,
  parameter int LANES  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ROWS*COLS*BYTE_W-1:0] in_data,
  input  logic                       in_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       abort,
  output logic [LANES*BYTE_W-1:0]    out_data,
  output logic [idx_w(ROWS)-1:0]     out_row,
  output logic [idx_w(COLS)-1:0]     out_col,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int RW    = idx_w(ROWS);
  localparam int CW    = idx_w(COLS);
  localparam int BLK_W = ROWS * COLS * BYTE_W;
  localparam int BW    = idx_w(BLK_W);

  if ((ROWS % LANES) != 0 || (COLS % LANES) != 0) begin : g_lanes_check
    $error("LANES must divide both ROWS and COLS");
  end

  state_t             state, state_next;
  logic [BLK_W-1:0]   block_q;
  order_t             mode_q;
  logic [RW-1:0]      row_q;
  logic [CW-1:0]      col_q;
  logic               cnt_last;
  logic               fire, last_fire, load;
  logic [LANES*BYTE_W-1:0] beat;

  assign out_valid = (state == ST_SEND);
  assign fire      = out_valid & out_ready;
  assign last_fire = fire & cnt_last;
  assign in_ready  = ~abort & ((state == ST_IDLE) | last_fire);
  assign load      = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // abort outranks everything; a load wins over the return to IDLE so
  // back-to-back blocks stream without a bubble.
  always_comb begin
    state_next = state;
    if (abort)          state_next = ST_IDLE;
    else if (load)      state_next = ST_SEND;
    else if (last_fire) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_q <= '0;
      mode_q  <= ORDER_ROW;
    end else if (load) begin
      block_q <= in_data;
      mode_q  <= order_t'(in_mode);
    end
  end

  slice_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .LANES(LANES),
    .RW   (RW),
    .CW   (CW)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(abort | load),
    .step (fire & ~abort),
    .mode (mode_q),
    .row  (row_q),
    .col  (col_q),
    .last (cnt_last)
  );

  // Lane l takes the l-th slice after (row,col) along the traversal direction.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BW-1:0] base;
    always_comb begin
      base = '0;
      if (mode_q == ORDER_COL)
        base = BW'(((int'(row_q) + l) * COLS + int'(col_q)) * BYTE_W);
      else
        base = BW'((int'(row_q) * COLS + int'(col_q) + l) * BYTE_W);
    end
    assign beat[l*BYTE_W +: BYTE_W] = block_q[base +: BYTE_W];
  end

  assign out_data = out_valid ? beat : '0;
  assign out_last = out_valid & cnt_last;
  assign out_row  = row_q;
  assign out_col  = col_q;

endmodule
